// File: rtl/regfile_mp.sv
// Multi-read-port register file: N registered read lanes, one byte-masked write with forwarding,
// optional zero entry 0, scrub engine that zeroes the array after reset or on clear_req. Read latency 1, no stalls.
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [READ_PORTS*ADDR_W-1:0] raddr,
  output logic [READ_PORTS*WIDTH-1:0]  rdata,
  input  logic                         wren,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [WIDTH/8-1:0]           wmask,
  input  logic                         clear_req,
  output logic                         busy
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   count, count_nx;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    wbits;
  logic                wr_ok;
  logic [READ_PORTS*WIDTH-1:0] rd_nx;

  // A write is honoured only in RUN, in range, and not aimed at a hardwired zero entry.
  assign wr_ok = (state == RUN) && wren && ({1'b0, waddr} < DEPTH_W) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    wbits = '0;
    for (int b = 0; b < NB; b++) begin
      wbits[8*b +: 8] = {8{wmask[b]}};
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      CLEAR: begin
        count_nx = count + 1'b1;
        if (count == LAST) begin
          state_nx = RUN;
          count_nx = '0;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_nx = CLEAR;
        end
      end
      default: begin
        state_nx = CLEAR;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  assign busy = (state == CLEAR);

  // Array has no reset; the scrub is the only initialisation. Writes are lost while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[count] <= '0;
      end else if (wr_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (wmask[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_lane
    logic [ADDR_W-1:0] a;
    logic              ok;
    logic              fwd;
    logic [WIDTH-1:0]  stored;

    assign a      = raddr[i*ADDR_W +: ADDR_W];
    assign ok     = ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    assign fwd    = wr_ok && (waddr == a);
    assign stored = mem[a];
    assign rd_nx[i*WIDTH +: WIDTH] = !ok ? '0 :
                                     fwd ? ((stored & ~wbits) | (wdata & wbits)) : stored;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (state == CLEAR) begin
      rdata <= '0;
    end else begin
      rdata <= rd_nx;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (DEPTH=256 with zero entry, DEPTH=24 without) against an array model.
module tb_regfile_mp;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] raddr0;
  logic [63:0] rdata0;
  logic        busy0;
  logic [9:0]  raddr1;
  logic [63:0] rdata1;
  logic        busy1;
  logic [4:0]  waddr1;

  logic [7:0]  ra [2][2];
  logic        we [2];
  logic [7:0]  wa [2];
  logic [31:0] wd [2];
  logic [3:0]  wm [2];
  logic        clr [2];

  assign raddr0 = {ra[0][1], ra[0][0]};
  assign raddr1 = {ra[1][1][4:0], ra[1][0][4:0]};
  assign waddr1 = wa[1][4:0];

  regfile_mp #(.WIDTH(32), .DEPTH(256), .READ_PORTS(2), .ZERO_REG(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .raddr(raddr0), .rdata(rdata0),
    .wren(we[0]), .waddr(wa[0]), .wdata(wd[0]), .wmask(wm[0]),
    .clear_req(clr[0]), .busy(busy0)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(24), .READ_PORTS(2), .ZERO_REG(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .raddr(raddr1), .rdata(rdata1),
    .wren(we[1]), .waddr(waddr1), .wdata(wd[1]), .wmask(wm[1]),
    .clear_req(clr[1]), .busy(busy1)
  );

  // Reference model: contents, remaining scrub edges, and expected read lanes.
  logic [31:0] mem_m [2][256];
  int          busy_left [2];
  int          depth_m [2] = '{256, 24};
  int          amask_m [2] = '{255, 31};
  bit          zr_m [2]    = '{1'b1, 1'b0};
  logic [31:0] exp_rd [2][2];
  int          nchecks = 0;
  int          nerrs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit addr_ok(input int d, input int a);
    return (a < depth_m[d]) && !(zr_m[d] && a == 0);
  endfunction

  task automatic model_scrub_start(input int d);
    for (int a = 0; a < 256; a++) mem_m[d][a] = '0;
    busy_left[d] = depth_m[d];
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int wa_i;
      wa_i = int'(wa[d]) & amask_m[d];
      if (busy_left[d] > 0) begin
        exp_rd[d][0] = '0;
        exp_rd[d][1] = '0;
        busy_left[d]--;
      end else begin
        for (int p = 0; p < 2; p++) begin
          int a;
          a = int'(ra[d][p]) & amask_m[d];
          if (!addr_ok(d, a)) exp_rd[d][p] = '0;
          else if (we[d] && wa_i == a) exp_rd[d][p] = merge(mem_m[d][a], wd[d], wm[d]);
          else exp_rd[d][p] = mem_m[d][a];
        end
        if (we[d] && addr_ok(d, wa_i)) mem_m[d][wa_i] = merge(mem_m[d][wa_i], wd[d], wm[d]);
        if (clr[d]) model_scrub_start(d);
      end
    end
    @(posedge clock);
    #1;
    check("d0_lane0", rdata0[31:0],  exp_rd[0][0]);
    check("d0_lane1", rdata0[63:32], exp_rd[0][1]);
    check("d1_lane0", rdata1[31:0],  exp_rd[1][0]);
    check("d1_lane1", rdata1[63:32], exp_rd[1][1]);
    check("d0_busy", {31'b0, busy0}, {31'b0, busy_left[0] > 0});
    check("d1_busy", {31'b0, busy1}, {31'b0, busy_left[1] > 0});
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      we[d]  = 1'b0;
      clr[d] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_d0", rdata0[31:0] | rdata0[63:32], 32'h0);
    check("rst_d1", rdata1[31:0] | rdata1[63:32], 32'h0);
    check("rst_busy", {30'b0, busy1, busy0}, 32'h3);
    for (int d = 0; d < 2; d++) model_scrub_start(d);
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic count_scrub(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 600 && busy0; k++) begin
      we[0] = 1'b1;
      wa[0] = 8'($urandom_range(0, 255));
      wd[0] = $urandom;
      wm[0] = 4'hF;
      tick();
      cnt++;
    end
    idle();
    check(tag, cnt, 256);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ra[d][0] = '0; ra[d][1] = '0; wa[d] = '0; wd[d] = '0; wm[d] = '0;
    end
    idle();
    #2;
    apply_reset();
    count_scrub("scrub_len_reset");

    for (int a = 0; a < 256; a++) begin
      ra[0][0] = 8'(a);
      ra[0][1] = 8'(255 - a);
      ra[1][0] = 8'(a % 32);
      ra[1][1] = 8'((a + 7) % 32);
      tick();
    end

    we[0] = 1'b1; wa[0] = 8'd5; wd[0] = 32'hDEADBEEF; wm[0] = 4'hF;
    tick();
    idle(); ra[0][0] = 8'd5;
    tick();
    check("basic_rd", rdata0[31:0], 32'hDEADBEEF);

    we[0] = 1'b1; wa[0] = 8'd7; wd[0] = 32'h11223344; wm[0] = 4'hF;
    tick();
    wd[0] = 32'hAABBCCDD; wm[0] = 4'b0101; ra[0][1] = 8'd7;
    tick();
    check("fwd_mask", rdata0[63:32], 32'h11BB33DD);
    idle(); ra[0][0] = 8'd7;
    tick();
    check("fwd_after", rdata0[31:0], 32'h11BB33DD);

    we[0] = 1'b1; wa[0] = 8'd0; wd[0] = 32'hFFFFFFFF; wm[0] = 4'hF;
    ra[0][0] = 8'd0; ra[0][1] = 8'd0;
    tick();
    check("zr_same_l0", rdata0[31:0], 32'h0);
    check("zr_same_l1", rdata0[63:32], 32'h0);
    idle();
    tick();
    check("zr_after", rdata0[31:0] | rdata0[63:32], 32'h0);

    we[1] = 1'b1; wa[1] = 8'd0; wd[1] = 32'hCAFEF00D; wm[1] = 4'hF;
    tick();
    for (int a = 1; a < 24; a++) begin
      wa[1] = 8'(a); wd[1] = $urandom; wm[1] = 4'hF;
      tick();
    end
    wa[1] = 8'd30; wd[1] = 32'h12345678; ra[1][0] = 8'd30; ra[1][1] = 8'd30;
    tick();
    check("oor_rd", rdata1[31:0] | rdata1[63:32], 32'h0);
    idle();
    for (int a = 0; a < 24; a++) begin
      ra[1][0] = 8'(a);
      ra[1][1] = 8'(23 - a);
      tick();
      if (a == 0) check("oor_e0", rdata1[31:0], 32'hCAFEF00D);
    end

    ra[1][0] = 8'd0;
    clr[0] = 1'b1; we[0] = 1'b1; wa[0] = 8'd9; wd[0] = 32'h99999999; wm[0] = 4'hF;
    tick();
    check("clr_busy", {31'b0, busy0}, 32'h1);
    clr[0] = 1'b0;
    for (int k = 1; k < 100; k++) begin
      we[0] = 1'b1; wa[0] = 8'($urandom_range(0, 255)); wd[0] = $urandom; wm[0] = 4'hF;
      ra[0][0] = wa[0];
      tick();
    end
    idle();
    check("pre_rst_d1", rdata1[31:0], 32'hCAFEF00D);
    apply_reset();
    count_scrub("scrub_len_rerun");
    for (int a = 0; a < 256; a++) begin
      ra[0][0] = 8'(a);
      ra[0][1] = 8'($urandom_range(0, 255));
      tick();
    end

    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 2; d++) begin
        int hi;
        hi = (d == 0) ? (($urandom_range(0, 3) == 0) ? 255 : 15) : 31;
        ra[d][0] = 8'($urandom_range(0, hi));
        ra[d][1] = 8'($urandom_range(0, hi));
        we[d]    = 1'($urandom_range(0, 1));
        wa[d]    = 8'($urandom_range(0, hi));
        wd[d]    = $urandom;
        wm[d]    = 4'($urandom_range(0, 15));
        clr[d]   = ($urandom_range(0, 499) == 0);
      end
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
